fft_digit_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_digit_reorder_if.sv | 14 +
 rtl/fft_reorder_bank.sv | 29 ++
 rtl/fft_digit_reorder.sv | 87 ++++++++
 tb/tb_fft_digit_reorder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT: sample width, frame
// length, bin index type and the base-4 digit swap used by the reorder stage.
package fft_pkg;

  localparam int DW = 16;
  localparam int N  = 16;

  typedef logic [3:0] idx_t;

  // Swapping the two base-4 digits maps digit-reversed order to natural order.
  function automatic idx_t digit_rev4(idx_t idx);
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage

// File: rtl/fft_digit_reorder_if.sv
// Complex-sample valid/ready stream. A transfer happens on a rising edge when
// valid & ready are both high; the master holds valid and data until it does.
interface fft_digit_reorder_if #(parameter int DW = fft_pkg::DW);

  logic                 valid;
  logic                 ready;
  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic                 last;

  modport master (output valid, re, im, last, input ready);
  modport slave  (input valid, re, im, last, output ready);

endinterface

// File: rtl/fft_reorder_bank.sv
// One 16-entry sample bank: synchronous write, combinational read, contents
// cleared by the asynchronous reset so outputs start at zero.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int W = 2 * DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  idx_t         waddr,
  input  logic [W-1:0] wdata,
  input  idx_t         raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_digit_reorder.sv
// Output reorder stage of the 16-point radix-4 FFT: frames arrive in base-4
// digit-reversed order and leave in natural bin order via two ping-pong banks.
module fft_digit_reorder
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fft_digit_reorder_if.slave   in_s,
  fft_digit_reorder_if.master  out_s,
  output logic                 frame_err
);

  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            wbank;
  logic            rbank;
  idx_t            wcnt;
  idx_t            rcnt;
  logic            in_fire;
  logic            out_fire;
  logic            in_end;
  logic            out_end;
  logic [2*DW-1:0] rdata [2];

  assign in_s.ready  = !full[wbank];
  assign out_s.valid = full[rbank];

  assign in_fire  = in_s.valid & in_s.ready;
  assign out_fire = out_s.valid & out_s.ready;
  assign in_end   = in_fire & (wcnt == idx_t'(N - 1));
  assign out_end  = out_fire & (rcnt == idx_t'(N - 1));

  // Writes scatter to the digit-swapped address; reads walk addresses linearly.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (in_fire && (wbank == 1'(b))),
      .waddr (digit_rev4(wcnt)),
      .wdata ({in_s.re, in_s.im}),
      .raddr (rcnt),
      .rdata (rdata[b])
    );
  end

  assign out_s.re   = rdata[rbank][2*DW-1:DW];
  assign out_s.im   = rdata[rbank][DW-1:0];
  assign out_s.last = out_s.valid & (rcnt == idx_t'(N - 1));

  // The write and read sides always own different banks, so both flag
  // updates can land in the same cycle without conflict.
  always_comb begin
    full_nxt = full;
    if (in_end)  full_nxt[wbank] = 1'b1;
    if (out_end) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        wcnt <= wcnt + idx_t'(1);
        if (in_end) wbank <= ~wbank;
      end
      if (out_fire) begin
        rcnt <= rcnt + idx_t'(1);
        if (out_end) rbank <= ~rbank;
      end
    end
  end

  // Framing is driven purely by the internal count; in_last is only audited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (in_fire && (in_s.last != (wcnt == idx_t'(N - 1)))) begin
      frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_digit_reorder.sv
// Self-checking bench for fft_digit_reorder: directed phases plus randomized
// valid/ready traffic scored against a natural-order frame model.
module tb_fft_digit_reorder;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic frame_err;

  always #5 clk = ~clk;

  fft_digit_reorder_if in_s ();
  fft_digit_reorder_if out_s ();

  fft_digit_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_s      (in_s.slave),
    .out_s     (out_s.master),
    .frame_err (frame_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] frame_buf [16];
  int          frame_fill   = 0;
  logic [31:0] exp_q [$];
  logic        err_model    = 1'b0;
  int          in_pos       = 0;
  int          out_count    = 0;
  int          in_stall_cnt = 0;
  logic        stalled_prev = 1'b0;
  logic [31:0] held_data;
  logic [31:0] e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, so it sees what the next rising edge will commit.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      check("frame_err", frame_err, err_model);
      if (stalled_prev) begin
        check("hold_valid", out_s.valid, 1'b1);
        check("hold_data", {out_s.re, out_s.im}, held_data);
      end
      if (in_s.valid && !in_s.ready) in_stall_cnt++;
      if (in_s.valid && in_s.ready) begin
        if (in_s.last != (frame_fill == 15)) err_model = 1'b1;
        frame_buf[frame_fill] = {in_s.re, in_s.im};
        frame_fill++;
        if (frame_fill == 16) begin
          // Natural bin n comes from input step (n mod 4)*4 + n div 4.
          for (int n = 0; n < 16; n++) exp_q.push_back(frame_buf[(n % 4) * 4 + n / 4]);
          frame_fill = 0;
        end
      end
      if (out_s.valid && out_s.ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", out_s.valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {out_s.re, out_s.im}, e);
          check("out_last", out_s.last, (exp_q.size() % 16) == 0);
        end
        out_count++;
      end
      stalled_prev = out_s.valid && !out_s.ready;
      held_data    = {out_s.re, out_s.im};
    end
  end

  task automatic model_reset();
    exp_q.delete();
    frame_fill = 0;
    err_model  = 1'b0;
    in_pos     = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_s.ready, 1'b1);
    check({tag, "_out_valid"}, out_s.valid, 1'b0);
    check({tag, "_out_last"}, out_s.last, 1'b0);
    check({tag, "_out_re"}, out_s.re, 16'h0);
    check({tag, "_out_im"}, out_s.im, 16'h0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  task automatic drive(input int n, input int p_valid, input int p_ready, input bit directed,
                       input int err_at, input int max_cycles, output int cyc);
    int sent;
    bit fired;
    sent = 0;
    cyc  = 0;
    in_s.valid = 1'b0;
    in_s.re = directed ? 16'(sent) : 16'($urandom);
    in_s.im = directed ? 16'(-sent) : 16'($urandom);
    while (sent < n && cyc < max_cycles) begin
      if (!in_s.valid) in_s.valid = ($urandom_range(99) < p_valid);
      in_s.last  = (in_pos == 15) ^ (sent == err_at);
      out_s.ready = ($urandom_range(99) < p_ready);
      @(negedge clk);
      fired = in_s.valid && in_s.ready;
      @(posedge clk);
      #1;
      cyc++;
      if (fired) begin
        sent++;
        in_pos     = (in_pos + 1) % 16;
        in_s.valid = 1'b0;
        in_s.re    = directed ? 16'(sent) : 16'($urandom);
        in_s.im    = directed ? 16'(-sent) : 16'($urandom);
      end
    end
    in_s.valid = 1'b0;
    in_s.last  = 1'b0;
    if (sent < n) check("drive_timeout", sent, n);
  endtask

  task automatic drain(input int p_ready, input int max_cycles, output int cyc);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      out_s.ready = ($urandom_range(99) < p_ready);
      @(posedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  int cyc;
  int base;

  initial begin
    in_s.valid  = 1'b0;
    in_s.re     = '0;
    in_s.im     = '0;
    in_s.last   = 1'b0;
    out_s.ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single directed frame: re=k, im=-k
    drive(16, 100, 100, 1'b1, -1, 100, cyc);
    check("single_in_cycles", cyc, 16);
    check("single_latency_valid", out_s.valid, 1'b1);
    check("single_bin0_re", out_s.re, 16'h0);
    check("single_bin0_im", out_s.im, 16'h0);
    check("single_bin0_last", out_s.last, 1'b0);
    drain(100, 100, cyc);
    check("single_drain_cycles", cyc, 16);

    // Back-to-back frames, no stalls anywhere
    base = out_count;
    in_stall_cnt = 0;
    drive(48, 100, 100, 1'b0, -1, 200, cyc);
    check("b2b_in_cycles", cyc, 48);
    check("b2b_outputs_during_feed", out_count - base, 32);
    drain(100, 100, cyc);
    check("b2b_drain_cycles", cyc, 16);
    check("b2b_in_stalls", in_stall_cnt, 0);
    check("b2b_total_outputs", out_count - base, 48);

    // Backpressure: both banks fill, input blocks until the first frame drains
    drive(32, 100, 0, 1'b0, -1, 200, cyc);
    check("bp_in_ready_full", in_s.ready, 1'b0);
    check("bp_out_valid", out_s.valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready_still", in_s.ready, 1'b0);
    out_s.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_s.ready, 1'b0);
      @(posedge clk);
      #1;
    end
    check("bp_in_ready_back", in_s.ready, 1'b1);
    drain(100, 100, cyc);

    // Random valid/ready over 20 frames
    base = out_count;
    drive(320, 50, 50, 1'b0, -1, 5000, cyc);
    drain(50, 1000, cyc);
    check("rand_outputs", out_count - base, 320);

    // Early in_last at step 7: flag sticks, framing unaffected
    base = out_count;
    drive(16, 100, 100, 1'b0, 7, 100, cyc);
    check("err_flag_set", frame_err, 1'b1);
    drain(100, 100, cyc);
    repeat (2) @(posedge clk);
    #1;
    check("err_flag_sticky", frame_err, 1'b1);
    check("err_frame_outputs", out_count - base, 16);

    // Reset mid-frame while a full bank is draining
    drive(16, 100, 0, 1'b0, -1, 100, cyc);
    drive(9, 100, 0, 1'b0, -1, 100, cyc);
    out_s.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = out_count;
    drive(16, 100, 100, 1'b1, -1, 100, cyc);
    check("post_rst_valid", out_s.valid, 1'b1);
    drain(100, 100, cyc);
    check("post_rst_outputs", out_count - base, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
